sort_sink: RTL and testbench

Downstream consumer of the per-source sorting stage's merged output stream. It accepts one flit per cycle with no backpressure towards the sorter, because the sorter has no ready input. It checks per-source key ordering, buffers flits in a small FIFO, and presents them to the network-interface/readout side through a valid/ready handshake. It also maintains sticky order-error and saturating drop/error counters for debug readout.

---
 rtl/sort_pkg.sv | 26 ++
 rtl/sort_sink_fifo.sv | 83 ++++++++
 rtl/sort_sink.sv | 135 +++++++++++++
 tb/tb_sort_sink.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared field widths, types and the saturating-increment helper for the sort_sink slice.
package sort_pkg;

   localparam int SORT_SRC_MIN  = 36;
   localparam int SORT_SRC_MAX  = 39;
   localparam int SORT_DATA_MIN = 2;
   localparam int SORT_DATA_MAX = 21;

   localparam int SRC_W = SORT_SRC_MAX - SORT_SRC_MIN + 1;
   localparam int KEY_W = SORT_DATA_MAX - SORT_DATA_MIN + 1;

   typedef logic [SRC_W-1:0] src_id_t;
   typedef logic [KEY_W-1:0] key_t;

   // Increment that sticks at the all-ones value of a counter `width` bits wide.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_v;
      max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      if (value >= max_v) begin
         sat_inc = max_v;
      end else begin
         sat_inc = value + 32'd1;
      end
   endfunction

endpackage

// File: rtl/sort_sink_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head and same-cycle push/pop.
module sort_sink_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop_ready,
   output logic [W-1:0] head_data,
   output logic         head_valid,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] rd_ptr_nxt_s;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic [W-1:0]  head_data_r;
   logic [W-1:0]  head_data_nxt_s;
   logic          head_valid_r;
   logic          full_s;
   logic          pop_s;
   logic          push_s;

   assign full_s = (count_r == CW'(DEPTH));
   assign pop_s  = head_valid_r & pop_ready;
   assign push_s = push & (~full_s | pop_s);
   assign drop   = push & full_s & ~pop_s;

   // Next pointer/occupancy; the head bypasses memory when the pushed word lands in the head slot.
   always_comb begin
      rd_ptr_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CW'(1);
         2'b01:   count_nxt_s = count_r - CW'(1);
         default: count_nxt_s = count_r;
      endcase
      if (count_nxt_s == CW'(0)) begin
         head_data_nxt_s = head_data_r;
      end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_data_nxt_s = push_data;
      end else begin
         head_data_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Storage array, written on every accepted push.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers, occupancy and the registered head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         count_r      <= {CW{1'b0}};
         head_data_r  <= {W{1'b0}};
         head_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         rd_ptr_r     <= rd_ptr_nxt_s;
         count_r      <= count_nxt_s;
         head_data_r  <= head_data_nxt_s;
         head_valid_r <= (count_nxt_s != CW'(0));
      end
   end

   assign head_data  = head_data_r;
   assign head_valid = head_valid_r;

endmodule

// File: rtl/sort_sink.sv
// Sink for the sorter's merged stream: per-source order checking (built only when
// SORT_SINK_ORDER_CHECK_EN is defined), drop-on-full buffering and debug counters.
module sort_sink
   import sort_pkg::*;
#(
   parameter int DATASIZE   = 40,
   parameter int SRC_MIN    = SORT_SRC_MIN,
   parameter int SRC_MAX    = SORT_SRC_MAX,
   parameter int DATA_MIN   = SORT_DATA_MIN,
   parameter int DATA_MAX   = SORT_DATA_MAX,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [DATASIZE-1:0]        data_in,
   input  logic                       valid_in,
   input  logic                       clr,
   output logic [DATASIZE-1:0]        data_out,
   output logic                       valid_out,
   input  logic                       ready_in,
   output logic                       order_err,
   output logic [SRC_MAX-SRC_MIN:0]   err_src,
   output logic [CNT_W-1:0]           err_cnt,
   output logic [CNT_W-1:0]           drop_cnt
);

   // Table/key types come from the package, so the field parameters must agree with it.
   if ((SRC_MAX - SRC_MIN + 1 != SRC_W) || (DATA_MAX - DATA_MIN + 1 != KEY_W)) begin : g_bad_field
      $error("sort_sink field parameters disagree with sort_pkg widths");
   end

   logic             drop_s;
   logic [CNT_W-1:0] drop_cnt_r;

   sort_sink_fifo #(
      .W     (DATASIZE),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (valid_in),
      .push_data (data_in),
      .pop_ready (ready_in),
      .head_data (data_out),
      .head_valid(valid_out),
      .drop      (drop_s)
   );

   // Drop counter; clr wins over an increment in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         drop_cnt_r <= {CNT_W{1'b0}};
      end else if (drop_s) begin
         drop_cnt_r <= CNT_W'(sat_inc(32'(drop_cnt_r), CNT_W));
      end
   end

   assign drop_cnt = drop_cnt_r;

`ifdef SORT_SINK_ORDER_CHECK_EN
   localparam int N_SRC = 1 << SRC_W;

   src_id_t          src_s;
   key_t             key_s;
   logic             viol_s;
   logic             seen_r     [N_SRC];
   key_t             last_key_r [N_SRC];
   logic             order_err_r;
   src_id_t          err_src_r;
   logic [CNT_W-1:0] err_cnt_r;

   assign src_s = data_in[SRC_MAX:SRC_MIN];
   assign key_s = data_in[DATA_MAX:DATA_MIN];

   // A flit arriving with clr sees the cleared table, so it can never be a violation.
   always_comb begin
      if (valid_in && !clr) begin
         viol_s = seen_r[src_s] & (key_s < last_key_r[src_s]);
      end else begin
         viol_s = 1'b0;
      end
   end

   // Order table: every flit (including dropped ones) records its key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SRC; i++) begin
            seen_r[i]     <= 1'b0;
            last_key_r[i] <= {KEY_W{1'b0}};
         end
      end else begin
         if (clr) begin
            for (int i = 0; i < N_SRC; i++) begin
               seen_r[i] <= 1'b0;
            end
         end
         if (valid_in) begin
            seen_r[src_s]     <= 1'b1;
            last_key_r[src_s] <= key_s;
         end
      end
   end

   // Sticky flag, first-offender capture and saturating violation count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         order_err_r <= 1'b0;
         err_src_r   <= {SRC_W{1'b0}};
         err_cnt_r   <= {CNT_W{1'b0}};
      end else if (clr) begin
         order_err_r <= 1'b0;
         err_src_r   <= {SRC_W{1'b0}};
         err_cnt_r   <= {CNT_W{1'b0}};
      end else if (viol_s) begin
         order_err_r <= 1'b1;
         if (!order_err_r) begin
            err_src_r <= src_s;
         end
         err_cnt_r <= CNT_W'(sat_inc(32'(err_cnt_r), CNT_W));
      end
   end

   assign order_err = order_err_r;
   assign err_src   = err_src_r;
   assign err_cnt   = err_cnt_r;
`else
   assign order_err = 1'b0;
   assign err_src   = {(SRC_MAX-SRC_MIN+1){1'b0}};
   assign err_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sort_sink.sv
// Scoreboard bench for sort_sink; order-check expectations follow SORT_SINK_ORDER_CHECK_EN.
module tb_sort_sink;

   localparam int DEPTH = 8;
`ifdef SORT_SINK_ORDER_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [39:0] data_in;
   logic        valid_in;
   logic        clr;
   logic [39:0] data_out;
   logic        valid_out;
   logic        ready_in;
   logic        order_err;
   logic [3:0]  err_src;
   logic [15:0] err_cnt;
   logic [15:0] drop_cnt;

   sort_sink dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .data_in  (data_in),
      .valid_in (valid_in),
      .clr      (clr),
      .data_out (data_out),
      .valid_out(valid_out),
      .ready_in (ready_in),
      .order_err(order_err),
      .err_src  (err_src),
      .err_cnt  (err_cnt),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   logic [39:0] sb[$];
   int          m_cnt;
   bit          m_seen[16];
   logic [19:0] m_last[16];
   logic        m_err;
   logic [3:0]  m_src;
   logic [15:0] m_ecnt;
   logic [15:0] m_drop;
   logic [39:0] m_out;

   function automatic logic [39:0] mk(input int src, input int key, input int tag);
      logic [3:0]  s;
      logic [19:0] k;
      logic [13:0] t;
      s = src[3:0];
      k = key[19:0];
      t = tag[13:0];
      return {s, t, k, 2'b01};
   endfunction

   task automatic model_reset();
      sb.delete();
      m_cnt  = 0;
      m_err  = 1'b0;
      m_src  = 4'd0;
      m_ecnt = 16'd0;
      m_drop = 16'd0;
      m_out  = 40'd0;
      for (int i = 0; i < 16; i++) begin
         m_seen[i] = 1'b0;
         m_last[i] = 20'd0;
      end
   endtask

   // Drive one cycle from a negedge, update the reference model, return at the next negedge.
   task automatic step(input bit vin, input logic [39:0] d, input bit rdy, input bit c);
      bit          pop;
      bit          full;
      logic [3:0]  s;
      logic [19:0] k;
      valid_in = vin;
      data_in  = d;
      ready_in = rdy;
      clr      = c;
      pop  = (m_cnt != 0) && rdy;
      full = (m_cnt == DEPTH);
      s = d[39:36];
      k = d[21:2];
      if (c) begin
         for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
         m_err  = 1'b0;
         m_src  = 4'd0;
         m_ecnt = 16'd0;
         m_drop = 16'd0;
      end
      if (vin) begin
         if (CHK_EN && m_seen[s] && (k < m_last[s])) begin
            if (!m_err) m_src = s;
            m_err = 1'b1;
            if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
         end
         m_seen[s] = 1'b1;
         m_last[s] = k;
         if (!full || pop) sb.push_back(d);
         else if (!c && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (pop) m_out = sb.pop_front();
      m_cnt = sb.size();
      @(posedge clk);
      @(negedge clk);
      valid_in = 1'b0;
      clr      = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid_in = 1'b0; data_in = 40'd0; clr = 1'b0; ready_in = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_out); end
      checks++; if (data_out !== 40'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_out); end
      checks++; if (order_err !== 1'b0 || err_src !== 4'd0) begin failures++; $display("FAIL reset_err got=%0b/%0d exp=0/0", order_err, err_src); end
      checks++; if (err_cnt !== 16'd0 || drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", err_cnt, drop_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_in_order();
      int src_t[7] = '{1, 2, 1, 4, 1, 2, 4};
      int key_t[7] = '{5, 3, 9, 7, 9, 3, 8};
      for (int i = 0; i < 7; i++) begin
         step(1'b1, mk(src_t[i], key_t[i], 100 + i), 1'b1, 1'b0);
         checks++;
         if (valid_out !== 1'b1 || data_out !== sb[0]) begin
            failures++; $display("FAIL in_order_head[%0d] got=%0b/%h exp=1/%h", i, valid_out, data_out, sb[0]);
         end
      end
      step(1'b0, 40'd0, 1'b1, 1'b0);
      checks++; if (valid_out !== 1'b0 || data_out !== m_out) begin failures++; $display("FAIL in_order_hold got=%0b/%h exp=0/%h", valid_out, data_out, m_out); end
      checks++; if (order_err !== m_err || err_cnt !== m_ecnt) begin failures++; $display("FAIL in_order_err got=%0b/%0d exp=%0b/%0d", order_err, err_cnt, m_err, m_ecnt); end
   endtask

   task automatic test_violation();
      step(1'b1, mk(5, 100, 200), 1'b1, 1'b0);
      checks++; if (order_err !== m_err) begin failures++; $display("FAIL viol_none got=%0b exp=%0b", order_err, m_err); end
      step(1'b1, mk(5, 40, 201), 1'b1, 1'b0);
      checks++; if (order_err !== m_err || err_src !== m_src || err_cnt !== m_ecnt) begin
         failures++; $display("FAIL viol_first got=%0b/%0d/%0d exp=%0b/%0d/%0d", order_err, err_src, err_cnt, m_err, m_src, m_ecnt);
      end
      step(1'b1, mk(6, 50, 202), 1'b1, 1'b0);
      step(1'b1, mk(6, 10, 203), 1'b1, 1'b0);
      checks++; if (order_err !== m_err || err_src !== m_src || err_cnt !== m_ecnt) begin
         failures++; $display("FAIL viol_second got=%0b/%0d/%0d exp=%0b/%0d/%0d", order_err, err_src, err_cnt, m_err, m_src, m_ecnt);
      end
      checks++; if (data_out !== sb[0]) begin failures++; $display("FAIL viol_data got=%h exp=%h", data_out, sb[0]); end
      step(1'b0, 40'd0, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      int popped = 0;
      for (int i = 0; i < 10; i++) step(1'b1, mk(7, 10 + i, 300 + i), 1'b0, 1'b0);
      checks++; if (drop_cnt !== m_drop) begin failures++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_cnt, m_drop); end
      checks++; if (valid_out !== 1'b1 || data_out !== sb[0]) begin failures++; $display("FAIL ovf_stable got=%0b/%h exp=1/%h", valid_out, data_out, sb[0]); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (valid_out !== (m_cnt != 0)) begin failures++; $display("FAIL ovf_valid[%0d] got=%0b exp=%0b", i, valid_out, m_cnt != 0); end
         if (m_cnt != 0) begin
            checks++; if (data_out !== sb[0]) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, data_out, sb[0]); end
            popped++;
         end
         step(1'b0, 40'd0, 1'b1, 1'b0);
      end
      checks++; if (popped != 8) begin failures++; $display("FAIL ovf_popped got=%0d exp=8", popped); end
   endtask

   task automatic test_full_push_pop();
      int popped = 0;
      for (int i = 0; i < 8; i++) step(1'b1, mk(8, 20 + i, 400 + i), 1'b0, 1'b0);
      step(1'b1, mk(8, 40, 408), 1'b1, 1'b0);
      checks++; if (drop_cnt !== m_drop) begin failures++; $display("FAIL fpp_drop got=%0d exp=%0d", drop_cnt, m_drop); end
      while (m_cnt != 0 && popped < 20) begin
         checks++; if (valid_out !== 1'b1 || data_out !== sb[0]) begin failures++; $display("FAIL fpp_data[%0d] got=%0b/%h exp=1/%h", popped, valid_out, data_out, sb[0]); end
         step(1'b0, 40'd0, 1'b1, 1'b0);
         popped++;
      end
      checks++; if (popped != 8 || valid_out !== 1'b0) begin failures++; $display("FAIL fpp_count got=%0d/%0b exp=8/0", popped, valid_out); end
   endtask

   task automatic test_sat_clr();
      for (int i = 0; i < 65536; i++) step(1'b1, mk(3, 20'hFFFFF - i, i), 1'b1, 1'b0);
      checks++; if (err_cnt !== m_ecnt || order_err !== m_err) begin failures++; $display("FAIL sat_full got=%0d/%0b exp=%0d/%0b", err_cnt, order_err, m_ecnt, m_err); end
      step(1'b1, mk(3, 7, 9999), 1'b1, 1'b0);
      checks++; if (err_cnt !== m_ecnt) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", err_cnt, m_ecnt); end
      step(1'b0, 40'd0, 1'b1, 1'b1);
      checks++; if (err_cnt !== 16'd0 || drop_cnt !== 16'd0 || order_err !== 1'b0 || err_src !== 4'd0) begin
         failures++; $display("FAIL clr_state got=%0d/%0d/%0b/%0d exp=0/0/0/0", err_cnt, drop_cnt, order_err, err_src);
      end
      step(1'b1, mk(3, 2, 9998), 1'b1, 1'b0);
      checks++; if (order_err !== m_err || err_cnt !== m_ecnt) begin failures++; $display("FAIL clr_noflag got=%0b/%0d exp=%0b/%0d", order_err, err_cnt, m_err, m_ecnt); end
      checks++; if (data_out !== sb[0]) begin failures++; $display("FAIL clr_data got=%h exp=%h", data_out, sb[0]); end
      step(1'b0, 40'd0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(1'b1, mk(9, 50 + i, 500 + i), 1'b0, 1'b0);
      step(1'b1, mk(9, 1, 505), 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (valid_out !== 1'b0 || data_out !== 40'd0) begin failures++; $display("FAIL rmid_out got=%0b/%h exp=0/0", valid_out, data_out); end
      checks++; if (order_err !== 1'b0 || err_src !== 4'd0 || err_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
         failures++; $display("FAIL rmid_dbg got=%0b/%0d/%0d/%0d exp=0/0/0/0", order_err, err_src, err_cnt, drop_cnt);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, mk(9, 0, 600), 1'b0, 1'b0);
      checks++; if (valid_out !== 1'b1 || data_out !== sb[0]) begin failures++; $display("FAIL rmid_lat got=%0b/%h exp=1/%h", valid_out, data_out, sb[0]); end
      checks++; if (order_err !== m_err) begin failures++; $display("FAIL rmid_order got=%0b exp=%0b", order_err, m_err); end
      step(1'b0, 40'd0, 1'b1, 1'b0);
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmid_drain got=%0b exp=0", valid_out); end
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_violation();
      test_overflow();
      test_full_push_pop();
      test_sat_clr();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
